// File: rtl/typing_session_ctrl_pkg.sv
// Shared types and constants for the typing-speed game session controller.
package typing_session_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_TYPING    = 2'd2,
        ST_FINISH    = 2'd3
    } state_t;

    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_ESC   = 9'h076;
    localparam logic [8:0] END_CODE  = 9'h000;

    localparam int unsigned CHARS_PER_WORD = 5;
    // chars per minute / chars per word, expressed against a per-second divisor
    localparam int unsigned WPM_SCALE      = 60 / CHARS_PER_WORD;

    function automatic logic [7:0] sat_u8(input logic [31:0] v);
        return (v > 32'd255) ? 8'hFF : v[7:0];
    endfunction

endpackage

// File: rtl/typing_session_ctrl_if.sv
// Key-strobe, text-ROM and result bus between decoder, controller and display.
interface typing_session_ctrl_if #(
    parameter int unsigned MAX_CHARS = 255
);
    localparam int unsigned CW = $clog2(MAX_CHARS + 1);

    logic          key_valid;
    logic [8:0]    key_code;
    logic [8:0]    target_code;
    logic          mode;
    logic [CW-1:0] char_idx;
    logic [1:0]    state;
    logic [3:0]    countdown_sec;
    logic [7:0]    elapsed_sec;
    logic [CW-1:0] correct_chars;
    logic [15:0]   error_count;
    logic [7:0]    wpm;
    logic          wpm_valid;

    modport master (
        output key_valid, key_code, target_code, mode,
        input  char_idx, state, countdown_sec, elapsed_sec,
               correct_chars, error_count, wpm, wpm_valid
    );

    modport slave (
        input  key_valid, key_code, target_code, mode,
        output char_idx, state, countdown_sec, elapsed_sec,
               correct_chars, error_count, wpm, wpm_valid
    );

endinterface

// File: rtl/typing_session_ctrl_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, abortable.
module typing_session_ctrl_seq_divider #(
    parameter int unsigned DW = 12,
    parameter int unsigned VW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient
);

    localparam int unsigned NW = $clog2(DW + 1);

    logic [DW-1:0] quo_q;
    logic [VW-1:0] rem_q;
    logic [VW-1:0] den_q;
    logic [NW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic [VW:0]   trial;
    logic          fits;

    always_comb begin
        trial = {rem_q, quo_q[DW-1]};
        fits  = (trial >= {1'b0, den_q});
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                quo_q  <= dividend;
                rem_q  <= '0;
                den_q  <= divisor;
                cnt_q  <= NW'(DW);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                // partial remainder always ends below the divisor, so VW bits suffice
                rem_q <= fits ? VW'(trial - {1'b0, den_q}) : trial[VW-1:0];
                quo_q <= {quo_q[DW-2:0], fits};
                cnt_q <= cnt_q - NW'(1);
                if (cnt_q == NW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/typing_session_ctrl.sv
// Typing-game session FSM: countdown, timed/text typing window, scoring and WPM result.
module typing_session_ctrl
    import typing_session_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned COUNTDOWN_S = 3,
    parameter int unsigned TEST_S      = 60,
    parameter int unsigned MAX_CHARS   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    typing_session_ctrl_if.slave  bus
);

    localparam int unsigned CW = $clog2(MAX_CHARS + 1);
    localparam int unsigned TW = $clog2(CLK_HZ);
    localparam int unsigned DW = CW + 4;

    state_t        state_q;
    logic          mode_q;
    logic [TW-1:0] tick_q;
    logic [3:0]    cd_q;
    logic [7:0]    el_q;
    logic [CW-1:0] idx_q;
    logic [CW-1:0] cor_q;
    logic [15:0]   err_q;
    logic [7:0]    wpm_q;
    logic          wv_q;
    logic          div_start_q;

    logic          key_enter;
    logic          key_esc;
    logic          tick_last;
    logic          text_done;
    logic          div_abort;
    logic          div_busy;
    logic          div_done;
    logic [DW-1:0] div_num;
    logic [8:0]    div_den;
    logic [DW-1:0] div_quo;

    always_comb begin
        key_enter = bus.key_valid && (bus.key_code == KEY_ENTER);
        key_esc   = bus.key_valid && (bus.key_code == KEY_ESC);
        tick_last = (tick_q == TW'(CLK_HZ - 1));
        text_done = (mode_q && (bus.target_code == END_CODE)) || (idx_q == CW'(MAX_CHARS));
        div_abort = (state_q == ST_FINISH) && (key_esc || key_enter) && (div_busy || div_start_q);
        div_num   = DW'(cor_q) * DW'(WPM_SCALE);
        // a partial second counts as a whole one so short sessions never divide by zero
        div_den   = 9'(el_q) + 9'(tick_q != '0);
        if (div_den == '0) div_den = 9'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            tick_q      <= '0;
            cd_q        <= '0;
            el_q        <= '0;
            idx_q       <= '0;
            cor_q       <= '0;
            err_q       <= '0;
            wpm_q       <= '0;
            wv_q        <= 1'b0;
            div_start_q <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (key_enter) begin
                        state_q <= ST_COUNTDOWN;
                        mode_q  <= bus.mode;
                        tick_q  <= '0;
                        cd_q    <= 4'(COUNTDOWN_S);
                        el_q    <= '0;
                        idx_q   <= '0;
                        cor_q   <= '0;
                        err_q   <= '0;
                        wpm_q   <= '0;
                        wv_q    <= 1'b0;
                    end
                end
                ST_COUNTDOWN: begin
                    if (key_esc) begin
                        state_q <= ST_IDLE;
                        wv_q    <= 1'b0;
                    end else if (tick_last) begin
                        tick_q <= '0;
                        if (cd_q == 4'd1) begin
                            cd_q    <= '0;
                            state_q <= ST_TYPING;
                        end else begin
                            cd_q <= cd_q - 4'd1;
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                ST_TYPING: begin
                    // end-of-text freezes the clock; timer expiry beats any same-cycle key
                    if (text_done) begin
                        state_q     <= ST_FINISH;
                        div_start_q <= 1'b1;
                    end else if (tick_last && (el_q == 8'(TEST_S - 1))) begin
                        tick_q      <= '0;
                        el_q        <= el_q + 8'd1;
                        state_q     <= ST_FINISH;
                        div_start_q <= 1'b1;
                    end else if (key_esc) begin
                        state_q <= ST_IDLE;
                        wv_q    <= 1'b0;
                    end else begin
                        if (tick_last) begin
                            tick_q <= '0;
                            if (el_q != 8'hFF) el_q <= el_q + 8'd1;
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                        if (bus.key_valid) begin
                            if (bus.key_code == bus.target_code) begin
                                idx_q <= idx_q + CW'(1);
                                cor_q <= cor_q + CW'(1);
                            end else if (err_q != 16'hFFFF) begin
                                err_q <= err_q + 16'd1;
                            end
                        end
                    end
                end
                ST_FINISH: begin
                    if (key_esc) begin
                        state_q <= ST_IDLE;
                        wv_q    <= 1'b0;
                    end else if (key_enter) begin
                        state_q <= ST_IDLE;
                    end else if (div_done) begin
                        wpm_q <= sat_u8(32'(div_quo));
                        wv_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    typing_session_ctrl_seq_divider #(
        .DW(DW),
        .VW(9)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_q),
        .abort    (div_abort),
        .dividend (div_num),
        .divisor  (div_den),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign bus.state         = state_q;
    assign bus.char_idx      = idx_q;
    assign bus.countdown_sec = cd_q;
    assign bus.elapsed_sec   = el_q;
    assign bus.correct_chars = cor_q;
    assign bus.error_count   = err_q;
    assign bus.wpm           = wpm_q;
    assign bus.wpm_valid     = wv_q;

endmodule

// File: tb/tb_typing_session_ctrl.sv
// Directed bench for typing_session_ctrl: 10 Hz main instance plus a MAX_CHARS=22 instance.
module tb_typing_session_ctrl;

    localparam logic [8:0] K_ENTER = 9'h05A;
    localparam logic [8:0] K_ESC   = 9'h076;
    localparam logic [8:0] K_WRONG = 9'h0AA;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int unsigned text_len = 0;

    always #5 clk = ~clk;

    typing_session_ctrl_if #(.MAX_CHARS(255)) bus();
    typing_session_ctrl_if #(.MAX_CHARS(22))  bus2();

    typing_session_ctrl #(
        .CLK_HZ(10), .COUNTDOWN_S(3), .TEST_S(6), .MAX_CHARS(255)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typing_session_ctrl #(
        .CLK_HZ(40), .COUNTDOWN_S(1), .TEST_S(6), .MAX_CHARS(22)
    ) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    function automatic logic [8:0] rom_code(input int unsigned idx, input int unsigned len);
        if (len != 0 && idx >= len) return 9'h000;
        return 9'(32'h10 + (idx % 32));
    endfunction

    always_comb bus.target_code  = rom_code(32'(bus.char_idx), text_len);
    always_comb bus2.target_code = rom_code(32'(bus2.char_idx), 0);

    task automatic press(input logic [8:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        @(negedge clk);
        bus.key_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_session(input logic m, input int unsigned len);
        text_len = len;
        bus.mode = m;
        press(K_ENTER);
        for (int k = 0; k < 40 && bus.state !== 2'd2; k++) @(negedge clk);
        n_checks++;
        if (bus.state !== 2'd2) begin n_fail++; $display("FAIL start_typing: got state %0d expected 2", bus.state); end
    endtask

    task automatic wait_finish();
        for (int k = 0; k < 100 && bus.state !== 2'd3; k++) @(negedge clk);
        n_checks++;
        if (bus.state !== 2'd3) begin n_fail++; $display("FAIL reach_finish: got state %0d expected 3", bus.state); end
    endtask

    task automatic wait_wpm(output int cyc);
        cyc = 0;
        while (bus.wpm_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.countdown_sec !== 4'd0) begin n_fail++; $display("FAIL rst_cd: got %0d expected 0", bus.countdown_sec); end
        n_checks++; if (bus.char_idx !== 8'd0 || bus.correct_chars !== 8'd0) begin n_fail++; $display("FAIL rst_idx: got %0d/%0d expected 0/0", bus.char_idx, bus.correct_chars); end
        n_checks++; if (bus.wpm !== 8'd0 || bus.wpm_valid !== 1'b0) begin n_fail++; $display("FAIL rst_wpm: got %0d/%0b expected 0/0", bus.wpm, bus.wpm_valid); end
        n_checks++; if (bus.error_count !== 16'd0 || bus.elapsed_sec !== 8'd0) begin n_fail++; $display("FAIL rst_err_el: got %0d/%0d expected 0/0", bus.error_count, bus.elapsed_sec); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_countdown();
        text_len = 0;
        bus.mode = 1'b0;
        press(K_WRONG);
        n_checks++; if (bus.state !== 2'd0) begin n_fail++; $display("FAIL idle_ignore: got %0d expected 0", bus.state); end
        bus.key_valid = 1'b1;
        bus.key_code  = K_ENTER;
        @(negedge clk);
        bus.key_valid = 1'b0;
        n_checks++; if (bus.state !== 2'd1 || bus.countdown_sec !== 4'd3) begin n_fail++; $display("FAIL cd_enter: got state %0d cd %0d expected 1/3", bus.state, bus.countdown_sec); end
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 9) begin n_checks++; if (bus.countdown_sec !== 4'd3) begin n_fail++; $display("FAIL cd_k9: got %0d expected 3", bus.countdown_sec); end end
            if (k == 10) begin n_checks++; if (bus.countdown_sec !== 4'd2) begin n_fail++; $display("FAIL cd_k10: got %0d expected 2", bus.countdown_sec); end end
            if (k == 20) begin n_checks++; if (bus.countdown_sec !== 4'd1) begin n_fail++; $display("FAIL cd_k20: got %0d expected 1", bus.countdown_sec); end end
            if (k == 29) begin n_checks++; if (bus.state !== 2'd1) begin n_fail++; $display("FAIL cd_k29_state: got %0d expected 1", bus.state); end end
            if (k == 30) begin n_checks++; if (bus.state !== 2'd2) begin n_fail++; $display("FAIL cd_k30_state: got %0d expected 2", bus.state); end end
        end
    endtask

    task automatic test_timed();
        int cyc;
        for (int i = 0; i < 5; i++) press(rom_code(i, 0));
        press(K_WRONG);
        for (int i = 5; i < 10; i++) press(rom_code(i, 0));
        press(K_WRONG);
        wait_finish();
        n_checks++; if (bus.elapsed_sec !== 8'd6) begin n_fail++; $display("FAIL timed_elapsed: got %0d expected 6", bus.elapsed_sec); end
        n_checks++; if (bus.correct_chars !== 8'd10 || bus.char_idx !== 8'd10) begin n_fail++; $display("FAIL timed_correct: got %0d/%0d expected 10/10", bus.correct_chars, bus.char_idx); end
        n_checks++; if (bus.error_count !== 16'd2) begin n_fail++; $display("FAIL timed_errors: got %0d expected 2", bus.error_count); end
        n_checks++; if (bus.wpm_valid !== 1'b0) begin n_fail++; $display("FAIL timed_early_valid: got %0b expected 0", bus.wpm_valid); end
        wait_wpm(cyc);
        n_checks++; if (cyc != 14) begin n_fail++; $display("FAIL timed_div_latency: got %0d expected 14", cyc); end
        n_checks++; if (bus.wpm !== 8'd20) begin n_fail++; $display("FAIL timed_wpm: got %0d expected 20", bus.wpm); end
    endtask

    task automatic test_text_mode();
        int cyc;
        press(K_ENTER);
        n_checks++; if (bus.state !== 2'd0 || bus.wpm !== 8'd20 || bus.wpm_valid !== 1'b1) begin n_fail++; $display("FAIL finish_enter_hold: got %0d/%0d/%0b expected 0/20/1", bus.state, bus.wpm, bus.wpm_valid); end
        start_session(1'b1, 4);
        for (int i = 0; i < 3; i++) press(rom_code(i, 4));
        repeat (10) @(negedge clk);
        press(rom_code(3, 4));
        wait_finish();
        n_checks++; if (bus.correct_chars !== 8'd4 || bus.char_idx !== 8'd4) begin n_fail++; $display("FAIL text_correct: got %0d/%0d expected 4/4", bus.correct_chars, bus.char_idx); end
        n_checks++; if (bus.elapsed_sec !== 8'd1) begin n_fail++; $display("FAIL text_elapsed: got %0d expected 1", bus.elapsed_sec); end
        wait_wpm(cyc);
        n_checks++; if (bus.wpm_valid !== 1'b1 || bus.wpm !== 8'd24) begin n_fail++; $display("FAIL text_wpm: got %0d valid %0b expected 24 valid 1", bus.wpm, bus.wpm_valid); end
        press(K_ENTER);
    endtask

    task automatic test_final_tick();
        int cyc;
        start_session(1'b0, 0);
        repeat (58) @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = rom_code(0, 0);
        @(negedge clk);
        bus.key_code  = rom_code(1, 0);
        @(negedge clk);
        bus.key_valid = 1'b0;
        n_checks++; if (bus.state !== 2'd3 || bus.elapsed_sec !== 8'd6) begin n_fail++; $display("FAIL tick_finish: got state %0d el %0d expected 3/6", bus.state, bus.elapsed_sec); end
        n_checks++; if (bus.correct_chars !== 8'd1 || bus.error_count !== 16'd0) begin n_fail++; $display("FAIL tick_key_dropped: got %0d/%0d expected 1/0", bus.correct_chars, bus.error_count); end
        wait_wpm(cyc);
        n_checks++; if (bus.wpm !== 8'd2) begin n_fail++; $display("FAIL tick_wpm: got %0d expected 2", bus.wpm); end
        press(K_ESC);
        n_checks++; if (bus.state !== 2'd0 || bus.wpm_valid !== 1'b0) begin n_fail++; $display("FAIL finish_esc: got %0d/%0b expected 0/0", bus.state, bus.wpm_valid); end
    endtask

    task automatic test_esc_typing();
        start_session(1'b0, 0);
        press(rom_code(0, 0));
        press(rom_code(1, 0));
        press(K_ESC);
        n_checks++; if (bus.state !== 2'd0 || bus.wpm_valid !== 1'b0) begin n_fail++; $display("FAIL esc_typing: got %0d/%0b expected 0/0", bus.state, bus.wpm_valid); end
        n_checks++; if (bus.correct_chars !== 8'd2 || bus.char_idx !== 8'd2) begin n_fail++; $display("FAIL esc_hold: got %0d/%0d expected 2/2", bus.correct_chars, bus.char_idx); end
    endtask

    task automatic test_zero_correct();
        int cyc;
        start_session(1'b0, 0);
        wait_finish();
        wait_wpm(cyc);
        n_checks++; if (bus.wpm_valid !== 1'b1 || bus.wpm !== 8'd0) begin n_fail++; $display("FAIL zero_wpm: got %0d valid %0b expected 0 valid 1", bus.wpm, bus.wpm_valid); end
        press(K_ENTER);
    endtask

    task automatic test_reset_during_div();
        start_session(1'b1, 4);
        for (int i = 0; i < 4; i++) press(rom_code(i, 4));
        wait_finish();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.state !== 2'd0 || bus.wpm_valid !== 1'b0 || bus.wpm !== 8'd0) begin n_fail++; $display("FAIL divrst_out: got %0d/%0b/%0d expected 0/0/0", bus.state, bus.wpm_valid, bus.wpm); end
        n_checks++; if (bus.correct_chars !== 8'd0 || bus.char_idx !== 8'd0 || bus.elapsed_sec !== 8'd0) begin n_fail++; $display("FAIL divrst_cnt: got %0d/%0d/%0d expected 0/0/0", bus.correct_chars, bus.char_idx, bus.elapsed_sec); end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (bus.wpm_valid !== 1'b0 || bus.state !== 2'd0) begin n_fail++; $display("FAIL divrst_stray: got valid %0b state %0d expected 0/0", bus.wpm_valid, bus.state); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bus2.mode      = 1'b0;
        bus2.key_valid = 1'b1;
        bus2.key_code  = K_ENTER;
        @(negedge clk);
        bus2.key_valid = 1'b0;
        for (int k = 0; k < 80 && bus2.state !== 2'd2; k++) @(negedge clk);
        n_checks++; if (bus2.state !== 2'd2) begin n_fail++; $display("FAIL b2b_start: got %0d expected 2", bus2.state); end
        for (int i = 0; i < 22; i++) begin
            bus2.key_valid = 1'b1;
            bus2.key_code  = rom_code(i, 0);
            @(negedge clk);
        end
        bus2.key_valid = 1'b0;
        for (int k = 0; k < 10 && bus2.state !== 2'd3; k++) @(negedge clk);
        n_checks++; if (bus2.state !== 2'd3 || bus2.elapsed_sec !== 8'd0) begin n_fail++; $display("FAIL max_finish: got state %0d el %0d expected 3/0", bus2.state, bus2.elapsed_sec); end
        n_checks++; if (bus2.correct_chars !== 5'd22 || bus2.char_idx !== 5'd22) begin n_fail++; $display("FAIL max_chars: got %0d/%0d expected 22/22", bus2.correct_chars, bus2.char_idx); end
        cyc = 0;
        while (bus2.wpm_valid !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
        n_checks++; if (cyc != 11) begin n_fail++; $display("FAIL max_div_latency: got %0d expected 11", cyc); end
        n_checks++; if (bus2.wpm !== 8'd255) begin n_fail++; $display("FAIL max_wpm_sat: got %0d expected 255", bus2.wpm); end
    endtask

    initial begin
        bus.key_valid  = 1'b0;
        bus.key_code   = '0;
        bus.mode       = 1'b0;
        bus2.key_valid = 1'b0;
        bus2.key_code  = '0;
        bus2.mode      = 1'b0;
        test_reset();
        test_countdown();
        test_timed();
        test_text_mode();
        test_final_tick();
        test_esc_typing();
        test_zero_correct();
        test_reset_during_div();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
